// File: rtl/medio_restador_pkg.sv
// Shared constants for the registered half/ripple-borrow subtractor slice.
// Holds the default operand width used when the top is not overridden.
package medio_restador_pkg;

    localparam int unsigned DefaultWidth = 1;

endpackage

// File: rtl/medio_restador_hs_bit.sv
// Combinational 1-bit half subtractor: difference and borrow-out of a - b.
// Two of these plus an OR of their borrows form one full-subtractor bit.
module hs_bit (
    input  logic a_i,
    input  logic b_i,
    output logic d_o,
    output logic bo_o
);

    assign d_o  = a_i ^ b_i;
    assign bo_o = ~a_i & b_i;

endmodule

// File: rtl/medio_restador.sv
// Registered ripple-borrow subtractor: dif = (A - B) mod 2**WIDTH, borrow = (A < B).
// Result appears one clock after the operands are sampled; rst_n clears it asynchronously.
module medio_restador
    import medio_restador_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] dif,
    output logic             borrow
);

    logic [WIDTH-1:0] dif_d;
    logic [WIDTH-1:0] chain;
    logic             borrow_d;
    logic [WIDTH-1:0] dif_q;
    logic             borrow_q;

    hs_bit u_bit0 (
        .a_i  (A[0]),
        .b_i  (B[0]),
        .d_o  (dif_d[0]),
        .bo_o (chain[0])
    );

    // Each upper bit subtracts B, then the incoming borrow, as two cascaded half subtractors.
    for (genvar i = 1; i < WIDTH; i++) begin : g_upper
        logic partDif;
        logic borHi;
        logic borLo;

        hs_bit u_hi (
            .a_i  (A[i]),
            .b_i  (B[i]),
            .d_o  (partDif),
            .bo_o (borHi)
        );

        hs_bit u_lo (
            .a_i  (partDif),
            .b_i  (chain[i-1]),
            .d_o  (dif_d[i]),
            .bo_o (borLo)
        );

        assign chain[i] = borHi | borLo;
    end

    assign borrow_d = chain[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dif_q    <= '0;
            borrow_q <= 1'b0;
        end else begin
            dif_q    <= dif_d;
            borrow_q <= borrow_d;
        end
    end

    assign dif    = dif_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_medio_restador.sv
// Scoreboard bench for medio_restador at WIDTH 1, 4 and 8: stimulus pushes expected
// {borrow,dif} into per-width queues, independent monitors pop and compare after each edge.
module tb_medio_restador;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a1, b1, dif1, bor1;
    logic [3:0] a4, b4, dif4;
    logic       bor4;
    logic [7:0] a8, b8, dif8;
    logic       bor8;
    logic       vld1, vld4, vld8;
    logic [8:0] q1[$];
    logic [8:0] q4[$];
    logic [8:0] q8[$];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    medio_restador #(.WIDTH(1)) u_dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .A      (a1),
        .B      (b1),
        .dif    (dif1),
        .borrow (bor1)
    );

    medio_restador #(.WIDTH(4)) u_dut4 (
        .clk    (clk),
        .rst_n  (rst_n),
        .A      (a4),
        .B      (b4),
        .dif    (dif4),
        .borrow (bor4)
    );

    medio_restador #(.WIDTH(8)) u_dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .A      (a8),
        .B      (b8),
        .dif    (dif8),
        .borrow (bor8)
    );

    // Packs a hand-computed result as {borrow,dif} with borrow sitting at bit w.
    function automatic logic [8:0] pack(input int w, input logic bor, input logic [7:0] d);
        logic [8:0] r;
        r = {1'b0, d};
        r[w] = bor;
        return r;
    endfunction

    // Reference: widened unsigned subtraction truncated to w+1 bits.
    function automatic logic [8:0] model(input int w, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] mask;
        logic [8:0] r;
        mask = (9'd1 << (w + 1)) - 9'd1;
        r = ({1'b0, a} & mask) - ({1'b0, b} & mask);
        return r & mask;
    endfunction

    task automatic checkOutput(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual={borrow,dif}=%h required=%h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int w, input logic [7:0] a, input logic [7:0] b,
                                 input logic [8:0] exp);
        @(negedge clk);
        vld1 = 1'b0;
        vld4 = 1'b0;
        vld8 = 1'b0;
        case (w)
            1: begin a1 = a[0]; b1 = b[0]; vld1 = 1'b1; q1.push_back(exp); end
            4: begin a4 = a[3:0]; b4 = b[3:0]; vld4 = 1'b1; q4.push_back(exp); end
            default: begin a8 = a; b8 = b; vld8 = 1'b1; q8.push_back(exp); end
        endcase
    endtask

    task automatic noExpected(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s output with empty scoreboard", name);
    endtask

    // Monitors: an operand captured at a rising edge is visible just after that edge.
    initial forever begin
        @(posedge clk);
        if (rst_n && vld1) begin
            #1;
            if (q1.size() == 0) noExpected("w1");
            else checkOutput("w1", {7'b0, bor1, dif1}, q1.pop_front());
        end
    end

    initial forever begin
        @(posedge clk);
        if (rst_n && vld4) begin
            #1;
            if (q4.size() == 0) noExpected("w4");
            else checkOutput("w4", {4'b0, bor4, dif4}, q4.pop_front());
        end
    end

    initial forever begin
        @(posedge clk);
        if (rst_n && vld8) begin
            #1;
            if (q8.size() == 0) noExpected("w8");
            else checkOutput("w8", {bor8, dif8}, q8.pop_front());
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_n = 1'b0;
        a1 = 1'b0; b1 = 1'b0;
        a4 = '0;   b4 = '0;
        a8 = '0;   b8 = '0;
        vld1 = 1'b0; vld4 = 1'b0; vld8 = 1'b0;

        #3;
        checkOutput("reset w1", {7'b0, bor1, dif1}, 9'h0);
        checkOutput("reset w4", {4'b0, bor4, dif4}, 9'h0);
        checkOutput("reset w8", {bor8, dif8}, 9'h0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(1, 8'd0, 8'd0, pack(1, 1'b0, 8'd0));
        applyStimulus(1, 8'd0, 8'd1, pack(1, 1'b1, 8'd1));
        applyStimulus(1, 8'd1, 8'd0, pack(1, 1'b0, 8'd1));
        applyStimulus(1, 8'd1, 8'd1, pack(1, 1'b0, 8'd0));

        // Async reset pulse between edges with A=0,B=1 held on the 1-bit instance.
        applyStimulus(1, 8'd0, 8'd1, pack(1, 1'b1, 8'd1));
        @(negedge clk);
        vld1 = 1'b0;
        #2 rst_n = 1'b0;
        #1 checkOutput("w1 async clear", {7'b0, bor1, dif1}, 9'h0);
        #1 rst_n = 1'b1;
        vld1 = 1'b1;
        q1.push_back(pack(1, 1'b1, 8'd1));

        applyStimulus(4, 8'd0, 8'd15, pack(4, 1'b1, 8'd1));
        applyStimulus(4, 8'd15, 8'd0, pack(4, 1'b0, 8'd15));
        applyStimulus(4, 8'd9, 8'd9, pack(4, 1'b0, 8'd0));
        applyStimulus(4, 8'd3, 8'd5, pack(4, 1'b1, 8'd14));
        applyStimulus(8, 8'd0, 8'd255, pack(8, 1'b1, 8'd1));
        applyStimulus(8, 8'd255, 8'd0, pack(8, 1'b0, 8'd255));
        applyStimulus(8, 8'd100, 8'd37, pack(8, 1'b0, 8'd63));
        applyStimulus(8, 8'd37, 8'd100, pack(8, 1'b1, 8'd193));

        for (int i = 0; i < 100; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom_range(0, 15));
            rb = 8'($urandom_range(0, 15));
            applyStimulus(4, ra, rb, model(4, ra, rb));
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            applyStimulus(8, ra, rb, model(8, ra, rb));
        end

        for (int ea = 0; ea < 16; ea++) begin
            for (int eb = 0; eb < 16; eb++) begin
                applyStimulus(4, 8'(ea), 8'(eb), model(4, 8'(ea), 8'(eb)));
            end
        end

        @(negedge clk);
        vld1 = 1'b0;
        vld4 = 1'b0;
        vld8 = 1'b0;
        repeat (3) @(negedge clk);

        checks++;
        if (q1.size() + q4.size() + q8.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain actual=%0d pending required=0",
                     q1.size() + q4.size() + q8.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
